// File: rtl/dmem_store_align.sv
// Store-side lane aligner: converts a byte-addressed store into one or two
// word-aligned memory write beats with byte enables and registered outputs.
module dmem_store_align #(
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int LENGTH_MUX        = 3
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic                         ReqValid,
  output logic                         ReqReady,
  input  logic [WIDTH_DATA_LENGTH-1:0] Addr,
  input  logic [WIDTH_DATA_LENGTH-1:0] DataIn,
  input  logic [LENGTH_MUX-1:0]        FormatSel,
  output logic                         MemValid,
  input  logic                         MemReady,
  output logic [WIDTH_DATA_LENGTH-1:0] MemAddr,
  output logic [WIDTH_DATA_LENGTH-1:0] MemWData,
  output logic [3:0]                   MemByteEn,
  output logic                         StoreErr,
  output logic                         Busy
);

  localparam int W = WIDTH_DATA_LENGTH;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t         state, state_n;
  logic           valid_n, err_n;
  logic [W-1:0]   addr_n, wdata_n;
  logic [3:0]     be_n;
  logic [W-1:0]   hi_data, hi_data_n;
  logic [3:0]     hi_be, hi_be_n;

  logic           legal;
  logic [3:0]     mask;
  logic [7:0]     wide8;
  logic [2*W-1:0] wide_d;

  assign ReqReady = (state == IDLE);
  assign Busy     = (state != IDLE);

  always_comb begin
    legal = 1'b1;
    mask  = '0;
    case (FormatSel)
      LENGTH_MUX'(0): mask = 4'b0001;
      LENGTH_MUX'(1): mask = 4'b0011;
      LENGTH_MUX'(2): mask = 4'b1111;
      default:        legal = 1'b0;
    endcase
    wide8  = {4'b0000, mask} << Addr[1:0];
    wide_d = {{W{1'b0}}, DataIn} << {Addr[1:0], 3'b000};
  end

  // Upper halves of the shifted lanes are captured at accept so the second
  // beat of a split store needs no further access to the request inputs.
  always_comb begin
    state_n   = state;
    valid_n   = MemValid;
    addr_n    = MemAddr;
    wdata_n   = MemWData;
    be_n      = MemByteEn;
    hi_data_n = hi_data;
    hi_be_n   = hi_be;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        if (ReqValid) begin
          if (legal) begin
            state_n   = BEAT0;
            valid_n   = 1'b1;
            addr_n    = {Addr[W-1:2], 2'b00};
            wdata_n   = wide_d[W-1:0];
            be_n      = wide8[3:0];
            hi_data_n = wide_d[2*W-1:W];
            hi_be_n   = wide8[7:4];
          end else begin
            err_n = 1'b1;
          end
        end
      end
      BEAT0: begin
        if (MemValid && MemReady) begin
          if (hi_be == 4'b0000) begin
            state_n = IDLE;
            valid_n = 1'b0;
          end else begin
            state_n = BEAT1;
            addr_n  = MemAddr + W'(4);
            wdata_n = hi_data;
            be_n    = hi_be;
          end
        end
      end
      BEAT1: begin
        if (MemValid && MemReady) begin
          state_n = IDLE;
          valid_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      MemValid  <= 1'b0;
      MemAddr   <= '0;
      MemWData  <= '0;
      MemByteEn <= '0;
      StoreErr  <= 1'b0;
      hi_data   <= '0;
      hi_be     <= '0;
    end else begin
      state     <= state_n;
      MemValid  <= valid_n;
      MemAddr   <= addr_n;
      MemWData  <= wdata_n;
      MemByteEn <= be_n;
      StoreErr  <= err_n;
      hi_data   <= hi_data_n;
      hi_be     <= hi_be_n;
    end
  end

endmodule

// File: tb/tb_dmem_store_align.sv
// Directed and randomized checks of dmem_store_align against a per-byte-lane
// reference model of store placement.
module tb_dmem_store_align;

  logic        Clk, Rst_n;
  logic        ReqValid, ReqReady;
  logic [31:0] Addr, DataIn;
  logic [2:0]  FormatSel;
  logic        MemValid, MemReady;
  logic [31:0] MemAddr, MemWData;
  logic [3:0]  MemByteEn;
  logic        StoreErr, Busy;

  int checks = 0;
  int errors = 0;

  dmem_store_align #(.WIDTH_DATA_LENGTH(32), .LENGTH_MUX(3)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady),
    .Addr(Addr), .DataIn(DataIn), .FormatSel(FormatSel),
    .MemValid(MemValid), .MemReady(MemReady),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemByteEn(MemByteEn),
    .StoreErr(StoreErr), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Each register byte k lands at byte address a+k; the memory word it hits and
  // its lane follow directly. Unstored bytes of DataIn still ride in lanes.
  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                       output logic [31:0] a0, output logic [31:0] d0, output logic [3:0] e0,
                       output bit split,
                       output logic [31:0] a1, output logic [31:0] d1, output logic [3:0] e1);
    int nb, off, k;
    nb  = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : 4;
    off = int'(a % 4);
    a0 = a - 32'(off);
    a1 = a0 + 32'd4;
    d0 = '0; d1 = '0; e0 = '0; e1 = '0;
    for (int j = 0; j < 4; j++) begin
      k = j - off;
      if (k >= 0) begin
        d0[8*j +: 8] = d[8*k +: 8];
        e0[j] = (k < nb);
      end
      k = j + 4 - off;
      if (k < 4) begin
        d1[8*j +: 8] = d[8*k +: 8];
        e1[j] = (k < nb);
      end
    end
    split = (off + nb > 4);
  endtask

  task automatic check_beat(input string tag, input logic [31:0] ea, input logic [31:0] ed,
                            input logic [3:0] ee);
    chk({tag, "_valid"}, 32'(MemValid), 32'd1);
    chk({tag, "_addr"}, MemAddr, ea);
    chk({tag, "_wdata"}, MemWData, ed);
    chk({tag, "_be"}, 32'(MemByteEn), 32'(ee));
    chk({tag, "_busy"}, 32'(Busy), 32'd1);
    chk({tag, "_ready"}, 32'(ReqReady), 32'd0);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that ends the store.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                          input int st0, input int st1);
    logic [31:0] a0, d0, a1, d1;
    logic [3:0]  e0, e1;
    bit          split;
    model(a, d, f, a0, d0, e0, split, a1, d1, e1);
    chk("req_ready_idle", 32'(ReqReady), 32'd1);
    ReqValid = 1'b1; Addr = a; DataIn = d; FormatSel = f; MemReady = 1'b0;
    @(posedge Clk); #1;
    ReqValid = 1'b0; Addr = $urandom; DataIn = $urandom; FormatSel = 3'd2;
    chk("no_err_legal", 32'(StoreErr), 32'd0);
    check_beat("beat0", a0, d0, e0);
    for (int i = 0; i < st0; i++) begin
      ReqValid = 1'b1;
      @(posedge Clk); #1;
      check_beat("beat0_stall", a0, d0, e0);
    end
    ReqValid = 1'b0; MemReady = 1'b1;
    @(posedge Clk); #1;
    MemReady = 1'b0;
    if (split) begin
      check_beat("beat1", a1, d1, e1);
      for (int i = 0; i < st1; i++) begin
        @(posedge Clk); #1;
        check_beat("beat1_stall", a1, d1, e1);
      end
      MemReady = 1'b1;
      @(posedge Clk); #1;
      MemReady = 1'b0;
    end
    chk("done_valid", 32'(MemValid), 32'd0);
    chk("done_busy", 32'(Busy), 32'd0);
    chk("done_ready", 32'(ReqReady), 32'd1);
  endtask

  initial begin
    Rst_n = 1'b0; ReqValid = 1'b0; Addr = '0; DataIn = '0; FormatSel = '0; MemReady = 1'b0;
    #3;
    chk("rst_valid", 32'(MemValid), 32'd0);
    chk("rst_err", 32'(StoreErr), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_addr", MemAddr, 32'd0);
    chk("rst_wdata", MemWData, 32'd0);
    chk("rst_be", 32'(MemByteEn), 32'd0);
    #9 Rst_n = 1'b1;
    @(posedge Clk); #1;
    chk("post_rst_ready", 32'(ReqReady), 32'd1);

    do_store(32'h100, 32'h12345678, 3'd2, 0, 0);
    do_store(32'h103, 32'h000000AB, 3'd0, 0, 0);
    do_store(32'h103, 32'h00008765, 3'd1, 0, 0);
    do_store(32'h102, 32'h0122E68F, 3'd2, 3, 3);

    ReqValid = 1'b1; Addr = 32'h200; DataIn = 32'hDEADBEEF; FormatSel = 3'b011;
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    chk("illegal_err", 32'(StoreErr), 32'd1);
    chk("illegal_valid", 32'(MemValid), 32'd0);
    chk("illegal_busy", 32'(Busy), 32'd0);
    do_store(32'h201, 32'h000000C3, 3'd0, 0, 0);
    chk("err_one_cycle", 32'(StoreErr), 32'd0);

    do_store(32'hFFFFFFFD, 32'hA5B6C7D8, 3'd2, 0, 1);

    ReqValid = 1'b1; Addr = 32'hFFFFFFFD; DataIn = 32'h11223344; FormatSel = 3'd2; MemReady = 1'b0;
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    chk("mid_rst_beat0", 32'(MemValid), 32'd1);
    #2 Rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(MemValid), 32'd0);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_addr", MemAddr, 32'd0);
    chk("mid_rst_be", 32'(MemByteEn), 32'd0);
    MemReady = 1'b1;
    #3 Rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      chk("no_beat1_after_rst", 32'(MemValid), 32'd0);
    end
    MemReady = 1'b0;
    do_store(32'h300, 32'hCAFEF00D, 3'd1, 0, 0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] ra, rd;
      logic [2:0]  rf;
      ra = $urandom; rd = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        rf = 3'($urandom_range(3, 7));
        ReqValid = 1'b1; Addr = ra; DataIn = rd; FormatSel = rf;
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        chk("rnd_illegal_err", 32'(StoreErr), 32'd1);
        chk("rnd_illegal_valid", 32'(MemValid), 32'd0);
        @(posedge Clk); #1;
        chk("rnd_err_cleared", 32'(StoreErr), 32'd0);
      end else begin
        rf = 3'($urandom_range(0, 2));
        do_store(ra, rd, rf, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
